// File: rtl/delay_rd_buf.sv
// Run-time programmable delay line: circular buffer with FILL/RUN validity tracking.
// Optional cfg_err output under `DELAY_RD_BUF_CFG_ERR_EN (flags clamped del_cfg loads).
module delay_rd_buf #(
  parameter int WIDTH   = 38,
  parameter int MAX_DEL = 16,
  parameter int CFG_W   = 5,
  parameter int DEF_DEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic [CFG_W-1:0] del_cfg,
  input  logic             cfg_load,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [CFG_W-1:0] cur_del
`ifdef DELAY_RD_BUF_CFG_ERR_EN
  ,
  output logic             cfg_err
`endif
);

  localparam int PTR_W = (MAX_DEL > 1) ? $clog2(MAX_DEL) : 1;
  localparam logic [CFG_W-1:0] MAX_C  = CFG_W'(MAX_DEL);
  localparam logic [CFG_W-1:0] DEF_C  = CFG_W'(DEF_DEL);
  localparam logic [CFG_W-1:0] ONE_C  = CFG_W'(1);
  localparam logic [PTR_W-1:0] LAST_P = PTR_W'(MAX_DEL - 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t            state, state_n;
  logic [PTR_W-1:0]  wptr, wptr_n, rd_idx;
  logic [CFG_W-1:0]  fill, fill_n, fill_inc, cur_n, cfg_clamped, back;
  logic [WIDTH-1:0]  dout_n, rd_data;
  logic              valid_n, we;
  int unsigned       wptr_i, back_i, rd_i;
  logic [WIDTH-1:0]  mem [MAX_DEL];

`ifdef DELAY_RD_BUF_CFG_ERR_EN
  logic cfg_err_n;
  assign cfg_err_n = cfg_load && ((del_cfg == '0) || (del_cfg > MAX_C));
`endif

  always_comb begin
    cfg_clamped = del_cfg;
    if (del_cfg == '0)
      cfg_clamped = ONE_C;
    else if (del_cfg > MAX_C)
      cfg_clamped = MAX_C;
  end

  // Read index = wptr - (D-1) mod MAX_DEL; the slot at wptr is written this
  // edge, so reading the old array contents gives read-before-write ordering.
  always_comb begin
    back   = cur_del - ONE_C;
    wptr_i = 32'(wptr);
    back_i = 32'(back);
    if (wptr_i >= back_i)
      rd_i = wptr_i - back_i;
    else
      rd_i = wptr_i + unsigned'(MAX_DEL) - back_i;
    rd_idx  = PTR_W'(rd_i);
    rd_data = (cur_del == ONE_C) ? din : mem[rd_idx];
  end

  assign fill_inc = fill + ONE_C;

  always_comb begin
    state_n = state;
    fill_n  = fill;
    wptr_n  = wptr;
    dout_n  = dout;
    valid_n = dout_valid;
    cur_n   = cur_del;
    we      = 1'b0;
    if (cfg_load) begin
      cur_n   = cfg_clamped;
      fill_n  = '0;
      state_n = FILL;
      dout_n  = '0;
      valid_n = 1'b0;
    end else if (en) begin
      we     = 1'b1;
      wptr_n = (wptr == LAST_P) ? '0 : wptr + PTR_W'(1);
      unique case (state)
        FILL: begin
          fill_n = fill_inc;
          if (fill_inc == cur_del) begin
            state_n = RUN;
            dout_n  = rd_data;
            valid_n = 1'b1;
          end else begin
            dout_n  = '0;
            valid_n = 1'b0;
          end
        end
        RUN: begin
          dout_n  = rd_data;
          valid_n = 1'b1;
        end
        default: state_n = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      wptr       <= '0;
      fill       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      cur_del    <= DEF_C;
    end else begin
      state      <= state_n;
      wptr       <= wptr_n;
      fill       <= fill_n;
      dout       <= dout_n;
      dout_valid <= valid_n;
      cur_del    <= cur_n;
    end
  end

`ifdef DELAY_RD_BUF_CFG_ERR_EN
  always_ff @(posedge clk) begin
    if (rst)
      cfg_err <= 1'b0;
    else
      cfg_err <= cfg_err_n;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst && we)
      mem[wptr] <= din;
  end

endmodule

// File: tb/tb_delay_rd_buf.sv
// Scoreboard bench for delay_rd_buf: driver pushes captured samples, monitor pops on valid output.
// Checks cfg_err too when DELAY_RD_BUF_CFG_ERR_EN is defined.
module tb_delay_rd_buf;

  logic        clk;
  logic        rst;
  logic        en;
  logic [37:0] din;
  logic [4:0]  del_cfg;
  logic        cfg_load;
  logic [37:0] dout;
  logic        dout_valid;
  logic [4:0]  cur_del;
`ifdef DELAY_RD_BUF_CFG_ERR_EN
  logic        cfg_err;
`endif

  delay_rd_buf #(.WIDTH(38), .MAX_DEL(16), .CFG_W(5), .DEF_DEL(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .del_cfg    (del_cfg),
    .cfg_load   (cfg_load),
    .dout       (dout),
    .dout_valid (dout_valid),
    .cur_del    (cur_del)
`ifdef DELAY_RD_BUF_CFG_ERR_EN
    ,
    .cfg_err    (cfg_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-behaviour model, updated by the driver just before each edge.
  logic [37:0] q[$];
  int          cnt     = 0;
  int          exp_del = 2;
  bit          exp_pop = 0;
  bit          exp_err = 0;
  int          total   = 0;
  int          passed  = 0;
  logic [37:0] prev_dout = '0;

  function automatic int clampd(input int c);
    if (c == 0) return 1;
    if (c > 16) return 16;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic e, input logic ld,
                      input logic [4:0] cfg, input logic [37:0] d);
    @(negedge clk);
    rst = r; en = e; cfg_load = ld; del_cfg = cfg; din = d;
    exp_err = !r && ld && (cfg == 5'd0 || cfg > 5'd16);
    if (r) begin
      q.delete(); cnt = 0; exp_del = 2; exp_pop = 0;
    end else if (ld) begin
      q.delete(); cnt = 0; exp_del = clampd(int'(cfg)); exp_pop = 0;
    end else if (e) begin
      q.push_back(d); cnt++; exp_pop = (cnt >= exp_del);
    end else begin
      exp_pop = 0;
    end
    @(posedge clk);
  endtask

  // Monitor: compares DUT outputs just after every edge.
  always @(posedge clk) begin
    logic [37:0] e;
    #1;
    chk("cur_del", 64'(cur_del), 64'(exp_del));
    chk("dout_valid", 64'(dout_valid), 64'(cnt >= exp_del));
`ifdef DELAY_RD_BUF_CFG_ERR_EN
    chk("cfg_err", 64'(cfg_err), 64'(exp_err));
`endif
    if (exp_pop && dout_valid) begin
      if (q.size() == 0) begin
        chk("pop_empty", 64'(q.size()), 64'd1);
      end else begin
        e = q.pop_front();
        chk("dout", 64'(dout), 64'(e));
      end
    end else if (cnt < exp_del) begin
      chk("dout_zero", 64'(dout), 64'd0);
    end else if (!exp_pop) begin
      chk("dout_hold", 64'(dout), 64'(prev_dout));
    end
    prev_dout = dout;
  end

  initial begin
    rst = 1'b1; en = 1'b0; cfg_load = 1'b0; del_cfg = '0; din = '0;
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 5'd7, 38'h55);            // rst dominates en and cfg_load
    for (int i = 1; i <= 10; i++) step(0, 1, 0, 0, 38'(i));
    step(0, 1, 1, 5'd16, 38'h3F);           // load MAX_DEL in RUN, din discarded
    for (int i = 0; i < 40; i++) step(0, 1, 0, 0, 38'hA5_0000 + 38'(i));
    step(0, 0, 1, 5'd3, 38'h77);            // load honoured with en=0
    for (int i = 0; i < 24; i++) begin
      if ((i % 4 == 0) || (i % 4 == 3)) step(0, 1, 0, 0, 38'hC00 + 38'(i));
      else                              step(0, 0, 0, 0, 38'h3F_FFFF_FFFF);
    end
    step(0, 1, 1, 5'd0, 0);                 // clamps to 1
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 38'h100 + 38'(i));
    step(0, 1, 1, 5'd31, 0);                // clamps to 16
    step(0, 1, 1, 5'd0, 0);
    step(0, 1, 1, 5'd20, 0);                // back-to-back: last wins
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 38'h200 + 38'(i));
    step(0, 1, 1, 5'd5, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 38'h300 + 38'(i));
    step(0, 1, 1, 5'd5, 0);                 // same D during FILL restarts
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 38'h400 + 38'(i));
    step(0, 1, 1, 5'd5, 0);                 // same D in RUN still flushes
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 38'h500 + 38'(i));
    step(1, 1, 1, 5'd9, 0);                 // rst alongside cfg_load mid-RUN
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 38'h600 + 38'(i));
    step(0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
